// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the register file: round-robin grant among NREQ writers plus a clear sweep.
// Build macro RFARB_HIPRI0_EN gives requester 0 fixed priority over a round-robin group 1..NREQ-1.
module regfile_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREGS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_start,
    output logic               clr_busy,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic [2:0]         grant_id
);
    localparam int PW = $clog2(NREQ);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
`ifdef RFARB_HIPRI0_EN
    localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
    localparam logic [PW-1:0] PTR_RST = '0;
`endif

    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt, win, cand;
    logic [AW-1:0] cnt;
    logic          found, grant;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // Rotating search for the first valid requester starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
`ifdef RFARB_HIPRI0_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                cand = PW'(1 + ((int'(ptr) - 1 + k) % (NREQ - 1)));
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
        ptr_nxt = (win == '0) ? ptr : (win == PW'(NREQ - 1)) ? PW'(1) : win + 1'b1;
`else
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    // clr_start outranks arbitration; reset masks ready so nothing is granted while it is held.
    assign grant     = found && (state == ARB) && !clr_start && !rst;
    assign req_ready = grant ? (NREQ'(1) << win) : '0;
    assign clr_busy  = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (clr_start) state_nxt = CLEAR;
            CLEAR:   if (cnt == LAST) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // cnt mirrors the sweep address currently on rf_waddr while in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= PTR_RST;
            cnt      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else begin
            state <= state_nxt;
            rf_we <= 1'b0;
            if (state == CLEAR) begin
                if (cnt != LAST) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= cnt + 1'b1;
                    rf_wdata <= '0;
                    cnt      <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                end
            end else if (clr_start) begin
                rf_we    <= 1'b1;
                rf_waddr <= '0;
                rf_wdata <= '0;
                cnt      <= '0;
            end else if (grant) begin
                rf_we    <= 1'b1;
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
                grant_id <= 3'(win);
                ptr      <= ptr_nxt;
            end
        end
    end
endmodule
